// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
// State encoding, one-hot grant values and the default watchdog limit.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie goes to the master that was not granted most recently.
module sdram_arb_rr_pick
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = GNT_NONE;
        case (req)
            2'b01:   grant = GNT_M0;
            2'b10:   grant = GNT_M1;
            2'b11:   grant = last ? GNT_M0 : GNT_M1;
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port,
// with round-robin grant, a mandatory stb gap and an ack timeout watchdog.
module sdram_wb_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = 10
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    arb_state_t    state, state_nxt;
    logic [1:0]    req;
    logic [1:0]    grant_q;
    logic          last;
    logic [TW-1:0] count;
    logic [1:0]    err_q;
    logic [1:0]    pick_gnt;
    logic          pick_valid;
    logic          req_g;
    logic          timeout_hit;
    logic          terminate;

    assign req         = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign req_g       = |(req & grant_q);
    assign timeout_hit = (count == TIMEOUT_CNT);
    assign terminate   = (state == BUSY) && (s_ack_i || !req_g || timeout_hit);

    assign grant_o   = grant_q;
    assign m0_err_o  = err_q[0];
    assign m1_err_o  = err_q[1];
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    sdram_arb_rr_pick u_pick (
        .req   (req),
        .last  (last),
        .grant (pick_gnt),
        .valid (pick_valid)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = BUSY;
            BUSY:    if (terminate)  state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack wins over a same-cycle timeout, so err only fires with s_ack_i low.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            grant_q <= GNT_NONE;
            last    <= 1'b1;
            count   <= '0;
            err_q   <= 2'b00;
        end else begin
            err_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_gnt;
                        count   <= '0;
                    end
                end
                BUSY: begin
                    count <= count + TW'(1);
                    if (terminate) begin
                        grant_q <= GNT_NONE;
                        last    <= grant_q[1];
                        if (timeout_hit && !s_ack_i) err_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_addr_o = 32'h0;
        s_data_o = 32'h0;
        if (state == BUSY) begin
            if (grant_q[1]) begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
            end else begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
            end
        end
        m0_ack_o = s_ack_i & grant_q[0] & req[0];
        m1_ack_o = s_ack_i & grant_q[1] & req[1];
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (TIMEOUT=8).
module tb_sdram_wb_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int checks   = 0;
    int failures = 0;

    sdram_wb_arbiter #(.TIMEOUT(8), .TW(10)) dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_sel_i  (m0_sel_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_sel_i  (m1_sel_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Inputs change 1ns after the edge; outputs are read 1ns after that.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0;
        m0_addr_i = 32'h0; m0_data_i = 32'h0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0;
        m1_addr_i = 32'h0; m1_data_i = 32'h0;
        s_ack_i = 0; s_data_i = 32'h0;
    endtask

    task automatic m0_req(input logic [31:0] addr);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF; m0_addr_i = addr;
    endtask

    task automatic m1_req(input logic [31:0] addr);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_addr_i = addr;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_grant_cyc: got grant=%b cyc=%b stb=%b want 00 0 0", grant_o, s_cyc_o, s_stb_o);
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o} !== 5'b0 || s_addr_o !== 32'h0 || s_sel_o !== 4'h0 || s_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ack/err/we=%b addr=%h sel=%h data=%h want all zero",
                     {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o}, s_addr_o, s_sel_o, s_data_o);
        end
        rst_n = 1;
    endtask

    task automatic test_single_read();
        m0_req(32'h0000_0100);
        settle();
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || s_addr_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL idle_outputs_zero: got grant=%b stb=%b addr=%h want 00 0 0", grant_o, s_stb_o, s_addr_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b01 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1 || s_addr_o !== 32'h100 || s_we_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_grant: got grant=%b stb=%b cyc=%b addr=%h we=%b want 01 1 1 100 0",
                     grant_o, s_stb_o, s_cyc_o, s_addr_o, s_we_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m0_ack_o !== 1'b0 || grant_o !== 2'b01 || m0_err_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL read_wait_%0d: got ack=%b grant=%b err=%b want 0 01 0", i, m0_ack_o, grant_o, m0_err_o);
            end
        end
        s_ack_i = 1;
        s_data_i = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (m0_ack_o !== 1'b1 || m0_data_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_ack: got m0_ack=%b data=%h m1_ack=%b want 1 deadbeef 0", m0_ack_o, m0_data_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0;
        m0_cyc_i = 0;
        m0_stb_i = 0;
        settle();
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_gap: got grant=%b stb=%b ack=%b err=%b want 00 0 0 0", grant_o, s_stb_o, m0_ack_o, m0_err_o);
        end
        tick();
    endtask

    task automatic test_tie_and_alternate();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
        test_reset();
        m0_req(32'h0000_1000);
        m1_req(32'h0000_2000);
        tick();
        checks++;
        if (grant_o !== 2'b01 || s_addr_o !== 32'h1000) begin
            failures++;
            $display("[TB] FAIL tie_first: got grant=%b addr=%h want 01 1000", grant_o, s_addr_o);
        end
        s_ack_i = 1;
        settle();
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_ack: got m0_ack=%b m1_ack=%b want 1 0", m0_ack_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0;
        m0_cyc_i = 0;
        m0_stb_i = 0;
        settle();
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_gap: got grant=%b stb=%b want 00 0", grant_o, s_stb_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_idle: got grant=%b stb=%b want 00 0", grant_o, s_stb_o);
        end
        tick();
        m0_req(32'h0000_1000);
        settle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_o !== exp_seq[i] || s_stb_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL alternate_%0d: got grant=%b stb=%b want %b 1", i, grant_o, s_stb_o, exp_seq[i]);
            end
            s_ack_i = 1;
            settle();
            checks++;
            if ({m1_ack_o, m0_ack_o} !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL alternate_ack_%0d: got acks=%b want %b", i, {m1_ack_o, m0_ack_o}, exp_seq[i]);
            end
            tick();
            s_ack_i = 0;
            settle();
            checks++;
            if (s_stb_o !== 1'b0 || grant_o !== 2'b00) begin
                failures++;
                $display("[TB] FAIL alternate_gap_%0d: got stb=%b grant=%b want 0 00", i, s_stb_o, grant_o);
            end
            tick();
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_write_abort();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011;
        m1_addr_i = 32'h0000_0200; m1_data_i = 32'h1234_5678;
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_sel_o !== 4'b0011 || s_data_o !== 32'h1234_5678 || s_we_o !== 1'b1 || s_addr_o !== 32'h200) begin
            failures++;
            $display("[TB] FAIL write_mux: got grant=%b sel=%b data=%h we=%b addr=%h want 10 0011 12345678 1 200",
                     grant_o, s_sel_o, s_data_o, s_we_o, s_addr_o);
        end
        tick();
        m1_stb_i = 0;
        settle();
        checks++;
        if (s_stb_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_stb: got stb=%b ack=%b want 0 0", s_stb_o, m1_ack_o);
        end
        tick();
        m1_cyc_i = 0;
        settle();
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || m1_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_gap: got grant=%b cyc=%b err=%b ack=%b want 00 0 0 0", grant_o, s_cyc_o, m1_err_o, m1_ack_o);
        end
        tick();
        m0_req(32'h0000_0300);
        m1_req(32'h0000_0400);
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL abort_last: got grant=%b want 01", grant_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        m0_req(32'h0000_0500);
        tick();
        m1_req(32'h0000_0600);
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (m0_err_o !== 1'b0 || grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL timeout_wait_%0d: got err=%b grant=%b stb=%b want 0 01 1", t, m0_err_o, grant_o, s_stb_o);
            end
        end
        tick();
        checks++;
        if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL timeout_err: got m0_err=%b m1_err=%b stb=%b grant=%b want 1 0 0 00",
                     m0_err_o, m1_err_o, s_stb_o, grant_o);
        end
        m0_cyc_i = 0;
        m0_stb_i = 0;
        tick();
        checks++;
        if (m0_err_o !== 1'b0 || s_stb_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_err_pulse: got err=%b stb=%b want 0 0", m0_err_o, s_stb_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_addr_o !== 32'h600) begin
            failures++;
            $display("[TB] FAIL timeout_next: got grant=%b addr=%h want 10 600", grant_o, s_addr_o);
        end
    endtask

    task automatic test_ack_at_timeout();
        for (int t = 1; t <= 8; t++) tick();
        s_ack_i = 1;
        s_data_i = 32'hCAFE_0008;
        settle();
        checks++;
        if (m1_ack_o !== 1'b1 || m1_data_o !== 32'hCAFE_0008) begin
            failures++;
            $display("[TB] FAIL ack_at_timeout: got ack=%b data=%h want 1 cafe0008", m1_ack_o, m1_data_o);
        end
        tick();
        s_ack_i = 0;
        m1_cyc_i = 0;
        m1_stb_i = 0;
        settle();
        checks++;
        if (m1_err_o !== 1'b0 || m0_err_o !== 1'b0 || grant_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL ack_at_timeout_noerr: got m1_err=%b m0_err=%b grant=%b want 0 0 00", m1_err_o, m0_err_o, grant_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m0_req(32'h0000_0700);
        tick();
        s_ack_i = 1;
        tick();
        s_ack_i = 0;
        m0_cyc_i = 0;
        m0_stb_i = 0;
        tick();
        m0_req(32'h0000_0700);
        m1_req(32'h0000_0800);
        tick();
        checks++;
        if (grant_o !== 2'b10) begin
            failures++;
            $display("[TB] FAIL pre_reset_tie: got grant=%b want 10", grant_o);
        end
        tick();
        rst_n = 0;
        tick();
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got cyc=%b stb=%b grant=%b ack=%b err=%b want 0 0 00 0 0",
                     s_cyc_o, s_stb_o, grant_o, m1_ack_o, m1_err_o);
        end
        rst_n = 1;
        tick();
        checks++;
        if (grant_o !== 2'b01 || s_addr_o !== 32'h700) begin
            failures++;
            $display("[TB] FAIL reset_release_tie: got grant=%b addr=%h want 01 700", grant_o, s_addr_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_and_alternate();
        test_write_abort();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
